// File: rtl/srl_chain_loader.sv
// Serial loader for a cascaded SRLC32E chain: shifts 32-bit words in MSB-first
// while capturing the displaced chain-end bits as the previous-contents word.
module srl_chain_loader #(
  parameter int unsigned NUM_SRL = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [31:0] WR_DATA,
  output logic        RD_VALID,
  input  logic        RD_READY,
  output logic [31:0] RD_DATA,
  output logic        RD_LAST,
  output logic        SRL_CE,
  output logic        SRL_D,
  input  logic        SRL_Q31,
  output logic        BUSY
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned CNT_W  = (NUM_SRL > 1) ? $clog2(NUM_SRL) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SRL - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  // S_INIT holds WR_READY low for the first cycle after reset release.
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SHIFT, S_RESP} state_e;

  state_e            state_q;
  logic [WORD_W-1:0] tx_q;
  logic [WORD_W-1:0] rx_q;
  logic [WORD_W-1:0] rx_d;
  logic [WORD_W-1:0] rd_data_q;
  logic [BIT_W-1:0]  bit_q;
  logic [CNT_W-1:0]  word_q;
  logic              ce_q;
  logic              d_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic              busy_q;

  // Pre-edge Q31 is appended on every shift edge.
  assign rx_d = {rx_q[WORD_W-2:0], SRL_Q31};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_INIT;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      ce_q       <= 1'b0;
      d_q        <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (WR_VALID) begin
            tx_q    <= WR_DATA;
            d_q     <= WR_DATA[WORD_W-1];
            ce_q    <= 1'b1;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          rx_q <= rx_d;
          tx_q <= tx_q << 1;
          if (bit_q == LAST_BIT) begin
            ce_q       <= 1'b0;
            d_q        <= 1'b0;
            rd_valid_q <= 1'b1;
            rd_data_q  <= rx_d;
            rd_last_q  <= (word_q == LAST_IDX);
            state_q    <= S_RESP;
          end else begin
            d_q   <= tx_q[WORD_W-2];
            bit_q <= bit_q + BIT_W'(1);
          end
        end
        S_RESP: begin
          if (RD_READY) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            word_q     <= (word_q == LAST_IDX) ? '0 : word_q + CNT_W'(1);
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign WR_READY = (state_q == S_IDLE);
  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign RD_LAST  = rd_last_q;
  assign SRL_CE   = ce_q;
  assign SRL_D    = d_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_srl_chain_loader.sv
// Scoreboard bench: two loaders (1-cell and 2-cell chains) driving behavioural SRL chains.
`timescale 1ns/1ps
module tb_srl_chain_loader;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: single SRL
  logic        a_wv, a_wr, a_rv, a_rr, a_last, a_ce, a_d, a_q, a_busy;
  logic [31:0] a_wd, a_rd;
  logic [31:0] a_srl0, a_init;
  logic        a_load;

  srl_chain_loader #(.NUM_SRL(1)) u_a (
    .CLK(clk), .RST_N(rst_n),
    .WR_VALID(a_wv), .WR_READY(a_wr), .WR_DATA(a_wd),
    .RD_VALID(a_rv), .RD_READY(a_rr), .RD_DATA(a_rd), .RD_LAST(a_last),
    .SRL_CE(a_ce), .SRL_D(a_d), .SRL_Q31(a_q), .BUSY(a_busy)
  );

  always @(posedge clk) begin
    if (a_load) a_srl0 <= a_init;
    else if (a_ce) a_srl0 <= {a_srl0[30:0], a_d};
  end
  assign a_q = a_srl0[31];

  // Instance B: two cascaded SRLs
  logic        b_wv, b_wr, b_rv, b_rr, b_last, b_ce, b_d, b_q, b_busy;
  logic [31:0] b_wd, b_rd;
  logic [31:0] b_srl0, b_srl1, b_init0, b_init1;
  logic        b_load;

  srl_chain_loader #(.NUM_SRL(2)) u_b (
    .CLK(clk), .RST_N(rst_n),
    .WR_VALID(b_wv), .WR_READY(b_wr), .WR_DATA(b_wd),
    .RD_VALID(b_rv), .RD_READY(b_rr), .RD_DATA(b_rd), .RD_LAST(b_last),
    .SRL_CE(b_ce), .SRL_D(b_d), .SRL_Q31(b_q), .BUSY(b_busy)
  );

  always @(posedge clk) begin
    if (b_load) begin
      b_srl0 <= b_init0;
      b_srl1 <= b_init1;
    end else if (b_ce) begin
      b_srl0 <= {b_srl0[30:0], b_d};
      b_srl1 <= {b_srl1[30:0], b_srl0[31]};
    end
  end
  assign b_q = b_srl1[31];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  exp_t        a_exp[$];
  exp_t        b_exp[$];
  exp_t        a_e, b_e;
  int unsigned a_hs = 0, b_hs = 0, a_acc = 0, b_acc = 0, a_run = 0, b_run = 0;

  // Monitors: handshakes, accepted words and CE burst length
  always @(negedge clk) begin
    if (!rst_n) begin
      a_run = 0;
    end else begin
      if (a_wv && a_wr) a_acc++;
      if (a_ce) a_run++;
      else if (a_run != 0) begin
        chk("a_ce_run", 64'(a_run), 64'd32);
        a_run = 0;
      end
      if (a_rv && a_rr) begin
        a_hs++;
        if (a_exp.size() == 0) chk("a_unexpected_rd", 64'd1, 64'd0);
        else begin
          a_e = a_exp.pop_front();
          chk("a_rd_data", 64'(a_rd), 64'(a_e.data));
          chk("a_rd_last", 64'(a_last), 64'(a_e.last));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_run = 0;
    end else begin
      if (b_wv && b_wr) b_acc++;
      if (b_ce) b_run++;
      else if (b_run != 0) begin
        chk("b_ce_run", 64'(b_run), 64'd32);
        b_run = 0;
      end
      if (b_rv && b_rr) begin
        b_hs++;
        if (b_exp.size() == 0) chk("b_unexpected_rd", 64'd1, 64'd0);
        else begin
          b_e = b_exp.pop_front();
          chk("b_rd_data", 64'(b_rd), 64'(b_e.data));
          chk("b_rd_last", 64'(b_last), 64'(b_e.last));
        end
      end
    end
  end

  task automatic a_write(input logic [31:0] w, input logic [31:0] old, input logic lst,
                         output int unsigned acc_cyc);
    int t = 0;
    a_exp.push_back('{data: old, last: lst});
    @(posedge clk); #1;
    a_wd = w;
    a_wv = 1'b1;
    while (!a_wr && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("a_wr_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    a_wv = 1'b0;
  endtask

  task automatic b_write(input logic [31:0] w, input logic [31:0] old, input logic lst,
                         input logic push);
    int t = 0;
    if (push) b_exp.push_back('{data: old, last: lst});
    @(posedge clk); #1;
    b_wd = w;
    b_wv = 1'b1;
    while (!b_wr && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("b_wr_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    b_wv = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((a_exp.size() != 0 || b_exp.size() != 0 || !a_wr || !b_wr) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int unsigned c0, c1, c2;
    int          t;
    logic [31:0] wexp;
    a_wv = 1'b0; a_wd = '0; a_rr = 1'b1;
    b_wv = 1'b0; b_wd = '0; b_rr = 1'b1;
    a_load = 1'b1; a_init = 32'hDEADBEEF;
    b_load = 1'b1; b_init0 = 32'hA5A5A5A5; b_init1 = 32'h0F0F0F0F;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_load = 1'b0;
    b_load = 1'b0;
    chk("rst_a_ctl", 64'({a_wr, a_rv, a_last, a_ce, a_d, a_busy}), 64'd0);
    chk("rst_a_rd", 64'(a_rd), 64'd0);
    chk("rst_b_ctl", 64'({b_wr, b_rv, b_last, b_ce, b_d, b_busy}), 64'd0);
    chk("rst_b_rd", 64'(b_rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("wr_ready_release", 64'({a_wr, b_wr}), 64'd0);
    @(posedge clk); #1;
    chk("wr_ready_after_rst", 64'({a_wr, b_wr}), 64'b11);

    // Single SRL: old INIT comes back, new word lands tap by tap
    a_write(32'h12345678, 32'hDEADBEEF, 1'b1, c0);
    chk("a_busy_shift", 64'({a_busy, a_ce, a_wr}), 64'b110);
    drain();
    wexp = 32'h12345678;
    for (int i = 0; i < 32; i++) chk("a_tap", 64'(a_srl0[i]), 64'(wexp[i]));

    // Back-to-back words with RD_READY high
    a_write(32'h00000000, 32'h12345678, 1'b1, c1);
    a_write(32'hFFFFFFFF, 32'h00000000, 1'b1, c2);
    chk("a_throughput", 64'(c2 - c1), 64'd34);
    drain();
    chk("a_final", 64'(a_srl0), 64'hFFFFFFFF);

    // Two-cell pass: displaced words come out last SRL first
    b_write(32'h11111111, 32'h0F0F0F0F, 1'b0, 1'b1);
    b_write(32'h22222222, 32'hA5A5A5A5, 1'b1, 1'b1);
    drain();
    chk("b_srl1", 64'(b_srl1), 64'h11111111);
    chk("b_srl0", 64'(b_srl0), 64'h22222222);

    // Backpressure with WR_VALID pulsing during SHIFT and RESP
    b_rr = 1'b0;
    b_write(32'h33333333, 32'h11111111, 1'b0, 1'b1);
    t = 0;
    while (!b_rv && t < 100) begin
      @(posedge clk); #1;
      b_wv = ~b_wv;
      b_wd = 32'hBAD00000 | 32'(t);
      t++;
    end
    if (t >= 100) chk("b_rv_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      b_wv = ~b_wv;
      chk("b_stall", 64'({b_rv, b_ce, b_wr, b_busy, b_rd}), {28'd0, 4'b1001, 32'h11111111});
    end
    b_wv = 1'b0;
    b_rr = 1'b1;
    @(posedge clk); #1;
    chk("b_release_idle", 64'({b_wr, b_busy, b_rv}), 64'b100);

    // Reset at shift cycle 10 with pass position 1
    b_write(32'h44444444, 32'h0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("b_ce_pre_rst", 64'({b_ce, b_busy}), 64'b11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("b_rst_async", 64'({b_ce, b_rv, b_busy, b_wr}), 64'd0);
    b_load = 1'b1; b_init0 = 32'hC3C3C3C3; b_init1 = 32'h5A5A5A5A;
    @(posedge clk); #1;
    b_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("b_wr_after_rst", 64'(b_wr), 64'd1);
    b_write(32'h66666666, 32'h5A5A5A5A, 1'b0, 1'b1);
    b_write(32'h77777777, 32'hC3C3C3C3, 1'b1, 1'b1);
    drain();
    chk("b_srl1_post", 64'(b_srl1), 64'h66666666);
    chk("b_srl0_post", 64'(b_srl0), 64'h77777777);

    chk("a_accepts", 64'(a_acc), 64'd3);
    chk("a_handshakes", 64'(a_hs), 64'd3);
    chk("b_accepts", 64'(b_acc), 64'd6);
    chk("b_handshakes", 64'(b_hs), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/srl_chain_loader.md
Name: srl_chain_loader

Overview:
Serial writer for a cascaded SRLC32E chain of NUM_SRL primitives, with D to Q31 linked SRL to SRL. It accepts 32-bit words over a valid/ready port and shifts each word MSB-first into the chain using CE/D. At the same time it captures the displaced bits from the chain-end Q31 and returns them as the previous-contents word. It is used to reprogram SRL-based lookup and delay contents at runtime and to read them back.

Parameters:
NUM_SRL, 1, number of cascaded SRLC32E cells; one load pass is NUM_SRL words (range 1..64).

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
WR_VALID  input  1  new word valid.
WR_READY  output  1  loader can accept a word.
WR_DATA  input  32  new SRL contents, bit i ends at SRL tap i.
RD_VALID  output  1  displaced word valid.
RD_READY  input  1  consumer accepts displaced word.
RD_DATA  output  32  displaced (previous) contents.
RD_LAST  output  1  RD_DATA is the final word of an NUM_SRL-word pass.
SRL_CE  output  1  clock enable to every SRL in the chain.
SRL_D  output  1  data into the first SRL of the chain.
SRL_Q31  input  1  Q31 of the last SRL in the chain.
BUSY  output  1  high while not IDLE.

Behaviour:
- Reset (async assert, sync-to-CLK deassert by the integrator): state IDLE, word counter 0, WR_READY=1 one cycle after RST_N high (0 while RST_N low), RD_VALID=0, RD_DATA=0, RD_LAST=0, SRL_CE=0, SRL_D=0, BUSY=0.
- SRL_CE, SRL_D, RD_* and BUSY are registered. WR_READY is decoded from the state register only.
- States:
  - IDLE: WR_READY=1. On WR_VALID&WR_READY at edge E0, latch WR_DATA into the tx shift register, clear the bit counter, go to SHIFT.
  - SHIFT: exactly 32 cycles. SRL_CE=1 and SRL_D=tx[31-k] in the k-th cycle (k=0..31). WR_VALID is ignored.
  - At each edge where SRL_CE=1, the chain shifts. On the same edge, rx <= {rx[30:0], SRL_Q31}, sampling the pre-edge Q31.
  - After the 32nd shift edge (E32), go to RESP. SRL_CE=0 in the cycle after E32; it never exceeds 32 consecutive cycles.
  - RESP: RD_VALID=1, RD_DATA=rx, RD_LAST=(word counter==NUM_SRL-1). Hold all three stable until RD_READY. On RD_VALID&RD_READY, drop RD_VALID, advance the word counter (wrap to 0 after NUM_SRL-1), go to IDLE.
- Latency: acceptance at E0 gives RD_VALID high after E32. Minimum period is 34 cycles per word (IDLE 1 + SHIFT 32 + RESP 1).
- Ordering: the first word accepted in a pass ends in the last SRL. The first RD_DATA of a pass is the old content of the last SRL, the next word is the old content of the next-to-last SRL, and so on.
  - With NUM_SRL=1, RD_LAST is always 1 and RD_DATA is exactly the previous INIT/contents.
- Backpressure: RD_READY low stalls in RESP indefinitely. SRL_CE stays 0 and WR_READY stays 0.
- RD_READY while RD_VALID=0 has no effect. WR_VALID may drop while WR_READY=0 without consequence.
- Reset mid-SHIFT: SRL_CE drops immediately (async). Chain contents are partially shifted and are undefined for the user. Counters restart at 0.
- Word counter width is max(1, clog2(NUM_SRL)). It tracks pass position only and is not exposed.
- Partial passes (fewer than NUM_SRL words) are legal. Chain contents are then rotated, and the counter keeps its value until a reset or until it completes.

Test Plan:
- NUM_SRL=1, SRLC32E INIT=32'hDEADBEEF, write 32'h12345678 -> SRL_CE high exactly 32 cycles; RD_DATA=32'hDEADBEEF, RD_LAST=1; SRL taps then read A=0..31 giving 32'h12345678 bit-by-bit.
- Same chain, write 32'h0 then 32'hFFFFFFFF -> RD_DATA 32'h12345678 then 32'h0; throughput 34 cycles/word with RD_READY tied high.
- NUM_SRL=2, INITs {SRL0=32'hA5A5A5A5, SRL1=32'h0F0F0F0F}, write W0=32'h11111111, W1=32'h22222222 -> RD_DATA 32'h0F0F0F0F (RD_LAST=0), then 32'hA5A5A5A5 (RD_LAST=1); final SRL1=32'h11111111, SRL0=32'h22222222.
- RD_READY held low 50 cycles in RESP -> RD_VALID/RD_DATA stable, SRL_CE=0, WR_READY=0, BUSY=1; release -> IDLE next cycle.
- Assert RST_N low at shift cycle 10 -> SRL_CE, RD_VALID, BUSY 0 immediately; after release WR_READY=1, next word gets RD_LAST per counter 0.
- WR_VALID pulsing during SHIFT and RESP -> no second acceptance; exactly one RD handshake per accepted word.
